// File: rtl/sd_bd_fifo.sv
// sd_bd_fifo: buffer-descriptor queue between the SD host interface and the
// data engine. Each BD is 64 bits: the source buffer address, then the SD block
// address. Both are stored as WPB words of DW bits, low half first when DW=16.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   flush                 synchronous clear of the whole queue
//   m_we, m_dat_in        host word write
//   free_bd               slots the host may still fill
//   wr_ovf                sticky flag: a write was dropped because the queue was full
//   bd_ready              committed BDs not yet fully read
//   s_re                  engine word read strobe
//   s_ack, s_dat_out      read data, valid one cycle after an accepted s_re
//   a_cmp                 transfer-complete level; each rising edge frees a slot
module sd_bd_fifo #(
    parameter  int DW     = 32,
    parameter  int BD_NUM = 4,
    localparam int WPB    = 64 / DW,
    localparam int AW     = $clog2(BD_NUM * WPB),
    localparam int CW     = $clog2(BD_NUM) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          m_we,
    input  logic [DW-1:0] m_dat_in,
    output logic [CW-1:0] free_bd,
    output logic          wr_ovf,
    output logic [CW-1:0] bd_ready,
    input  logic          s_re,
    output logic          s_ack,
    output logic [DW-1:0] s_dat_out,
    input  logic          a_cmp
);

    localparam int            WB   = $clog2(WPB);
    localparam logic [CW-1:0] FULL = CW'(BD_NUM);

    logic [DW-1:0] r_mem [BD_NUM*WPB];
    logic [AW-1:0] r_wr_pnt, r_rd_pnt;
    logic [CW-1:0] r_free, r_ready;
    logic          r_commit, r_cmp_d, r_ovf, r_ack;
    logic [DW-1:0] r_dat;

    // Slots are aligned to WPB words, so the word counters are the low
    // pointer bits.
    logic          w_wr_last, w_rd_last;
    logic          w_space, w_wr, w_rd, w_rise, w_rel;
    logic [CW-1:0] w_free_c;

    // A BD whose last word was written last cycle has not yet left free_bd.
    // Count it now so the host cannot start a BD in a slot that is already
    // owned.
    assign w_free_c  = r_free - CW'(r_commit);
    assign w_space   = (w_free_c != '0);
    assign w_wr      = m_we & w_space;
    assign w_wr_last = w_wr & (&r_wr_pnt[WB-1:0]);
    assign w_rd      = s_re & (r_ready != '0);
    assign w_rd_last = w_rd & (&r_rd_pnt[WB-1:0]);
    assign w_rise    = a_cmp & ~r_cmp_d;
    // A release with nothing outstanding is dropped, so free_bd saturates.
    assign w_rel     = w_rise & (w_free_c != FULL);

    always_ff @(posedge clk) begin
        if (w_wr && !flush) r_mem[r_wr_pnt] <= m_dat_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_pnt <= '0;
            r_rd_pnt <= '0;
            r_free   <= FULL;
            r_ready  <= '0;
            r_commit <= 1'b0;
            r_cmp_d  <= 1'b0;
            r_ovf    <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
        end else if (flush) begin
            r_wr_pnt <= '0;
            r_rd_pnt <= '0;
            r_free   <= FULL;
            r_ready  <= '0;
            r_commit <= 1'b0;
            r_cmp_d  <= 1'b0;
            r_ovf    <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
        end else begin
            r_cmp_d  <= a_cmp;
            r_commit <= w_wr_last;
            if (w_wr) r_wr_pnt <= r_wr_pnt + 1'b1;
            if (m_we && !w_space) r_ovf <= 1'b1;
            // Commit and release net out in the same cycle; neither is lost.
            r_free  <= w_free_c + CW'(w_rel);
            r_ready <= r_ready + CW'(r_commit) - CW'(w_rd_last);
            r_ack   <= w_rd;
            if (w_rd) begin
                r_dat    <= r_mem[r_rd_pnt];
                r_rd_pnt <= r_rd_pnt + 1'b1;
            end
        end
    end

    assign free_bd   = r_free;
    assign bd_ready  = r_ready;
    assign wr_ovf    = r_ovf;
    assign s_ack     = r_ack;
    assign s_dat_out = r_dat;

endmodule

// File: doc/sd_bd_fifo.md
Name: sd_bd_fifo

Overview:
- Parametrised buffer-descriptor (BD) queue for the SD controller. Successor to the fixed 16/32-bit BD store.
- Host side writes BDs word by word. Each BD is a 64-bit pair: source buffer address followed by SD block address.
- Data engine side reads committed BDs in order and returns slots with a completion strobe.
- Adds generic width and depth, a ready-BD count, a read guard, a flush, an overflow flag, and lossless simultaneous commit/release.

Parameters:
- DW, 32, data word width; legal values 16 or 32.
- BD_NUM, 4, number of BD slots; power of two, 2..64.
- WPB, 64/DW, words per BD (derived localparam; 2 or 4).
- AW, log2(BD_NUM*WPB), memory pointer width (derived).
- CW, log2(BD_NUM)+1, width of the slot counters (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous clear of the whole queue, single-cycle pulse
- m_we  in  1  host write strobe, one word per cycle
- m_dat_in  in  DW  host write data
- free_bd  out  CW  slots available to the host
- wr_ovf  out  1  sticky: write attempted while free_bd==0
- bd_ready  out  CW  committed BDs not yet fully read
- s_re  in  1  engine read strobe, one word per cycle
- s_ack  out  1  read data valid
- s_dat_out  out  DW  read data
- a_cmp  in  1  transfer complete level; the rising edge releases one slot

Behaviour:
- Reset and flush values: free_bd=BD_NUM, bd_ready=0, wr_ovf=0, s_ack=0, s_dat_out=0. All pointers, word counters and the a_cmp edge register are 0.
- flush is sampled on clk and overrides m_we, s_re and a_cmp in the same cycle. Memory contents are don't-care after flush.
- Write path: m_we with free_bd>0 stores m_dat_in at wr_pnt, then increments wr_pnt (wraps mod BD_NUM*WPB) and wcnt (0..WPB-1, wraps).
  - Word order within a BD: source address first, SD block address second; for DW=16 the low half precedes the high half.
  - A write with wcnt==WPB-1 commits the BD: a one-cycle internal commit pulse is issued the next cycle.
- Write while free_bd==0: data is dropped, pointers are unchanged, and wr_ovf is set. wr_ovf stays set until reset or flush.
- A partially written BD does not consume a slot. If the host stops mid-BD, later words continue that same BD.
- Slot accounting, evaluated each cycle:
  - commit alone: free_bd-1.
  - a_cmp rising edge alone (a_cmp=1, previous sample 0): free_bd+1.
  - Both in the same cycle: free_bd unchanged; neither event is lost.
  - A release while free_bd==BD_NUM is ignored; free_bd saturates.
  - The a_cmp history register is updated every cycle.
- Ready accounting: a commit adds 1 to bd_ready; completing a BD read (rcnt==WPB-1 accepted) subtracts 1. Both in the same cycle leave it unchanged.
- Read path: s_re with bd_ready>0 is accepted.
  - s_dat_out <= mem[rd_pnt], s_ack=1 in the next cycle (latency 1).
  - rd_pnt and rcnt increment with the same wrap rules as the write side.
- s_re with bd_ready==0: ignored, s_ack=0 next cycle, s_dat_out holds its value.
- s_ack is high for exactly one cycle per accepted read. Back-to-back s_re yields back-to-back s_ack.
- A read of a word in the same cycle as a write to the same slot cannot occur. A committed slot is not rewritten until it is released through a_cmp.
- Invariant: bd_ready <= BD_NUM - free_bd.

Test Plan:
- DW=32, BD_NUM=4: write 0x1000, 0x0020 -> free_bd 4->3 two cycles after the first write, bd_ready=1. Then s_re x2 -> s_dat_out 0x1000 then 0x0020 with s_ack on the cycles after, bd_ready=0.
- Fill 4 BDs (8 writes), then a 9th write of 0xDEAD -> free_bd=0, wr_ovf=1. Read all 8 words: none equals 0xDEAD, the order is preserved, and pointers wrap on the next fill after releases.
- Hold a_cmp high for 5 cycles after one commit -> exactly one release; free_bd returns to 4. A second pulse while free_bd=4 -> stays 4.
- a_cmp rising edge in the same cycle as a commit pulse, with free_bd=2 -> free_bd stays 2. s_re with bd_ready=0 -> no s_ack.
- DW=16: write 4 words 0x0001, 0x0002, 0x0003, 0x0004 -> one commit after the 4th word. Read returns the same order; a stop after 2 words does not change free_bd.
- Flush mid-BD (1 of 2 words written, bd_ready=2, wr_ovf=1) -> next cycle free_bd=4, bd_ready=0, wr_ovf=0. The next 2 writes form a fresh BD read back at word 0. Async rst mid-read -> s_ack=0 immediately.
